// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register selects, hazard FSM states and the control bundle
// that the hazard controller drives into the pipeline registers.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_wen;
        logic if_w;
        logic id_w;
        logic ex_w;
        logic mem_w;
        logic if_flush;
        logic id_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_GO       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_SQUASH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Hold PC and IF/ID, send a bubble down into ID/EX.
    localparam pipe_ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    function automatic logic load_use(input logic dren, input regbits_t wsel,
                                      input regbits_t rs, input regbits_t rt);
        return dren && (wsel != '0) && ((wsel == rs) || (wsel == rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-wait FSM plus combinational stall/flush control
// for a 5-stage pipeline, with a saturating stall-cycle counter.
module hazard_controller
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_dren,
    input  logic     mem_dwen,
    input  logic     mem_halt,
    input  logic     ex_redirect,
    input  logic     ex_dren,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     pc_wen,
    output logic     if_w,
    output logic     id_w,
    output logic     ex_w,
    output logic     mem_w,
    output logic     if_flush,
    output logic     id_flush,
    output logic     halted,
    output logic [15:0] stall_cnt
);

    hazard_state_t state, state_nxt;
    pipe_ctrl_t    ctrl;
    logic          mem_busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= state_nxt;
    end

    assign mem_busy = (mem_dren | mem_dwen) & ~dhit;

    always_comb begin
        ctrl      = CTRL_GO;
        state_nxt = state;
        if (state == HALT) begin
            ctrl = CTRL_FREEZE;
        end else if ((state == RUN) && mem_halt) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = HALT;
        end else if (mem_busy) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = DWAIT;
        end else if ((state == DWAIT) && dhit) begin
            ctrl      = CTRL_GO;
            state_nxt = RUN;
        end else begin
            // DWAIT with nothing pending also falls back to RUN here.
            state_nxt = RUN;
            if (ex_redirect)
                ctrl = CTRL_SQUASH;
            else if (load_use(ex_dren, ex_wsel, id_rs, id_rt))
                ctrl = CTRL_BUBBLE;
            else if (!ihit)
                ctrl = CTRL_BUBBLE;
        end
    end

    assign pc_wen   = ctrl.pc_wen;
    assign if_w     = ctrl.if_w;
    assign id_w     = ctrl.id_w;
    assign ex_w     = ctrl.ex_w;
    assign mem_w    = ctrl.mem_w;
    assign if_flush = ctrl.if_flush;
    assign id_flush = ctrl.id_flush;
    assign halted   = (state == HALT);

    sat_counter #(.W(16)) u_stall_cnt (
        .gclk   (CLK),
        .grst_n (nRST),
        .en     (~ctrl.pc_wen && (state != HALT)),
        .count  (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: table of combinational vectors in RUN plus
// hand-written sequences for memory wait, halt, reset and counter saturation.
module tb_hazard_controller;
    import cpu_types_pkg::*;

    logic CLK = 1'b0, nRST = 1'b0;
    logic ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_redirect, ex_dren;
    regbits_t ex_wsel, id_rs, id_rt;
    logic pc_wen, if_w, id_w, ex_w, mem_w, if_flush, id_flush, halted;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    hazard_controller dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .ex_redirect(ex_redirect), .ex_dren(ex_dren), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .pc_wen(pc_wen), .if_w(if_w),
        .id_w(id_w), .ex_w(ex_w), .mem_w(mem_w), .if_flush(if_flush),
        .id_flush(id_flush), .halted(halted), .stall_cnt(stall_cnt)
    );

    // {pc_wen, if_w, id_w, ex_w, mem_w, if_flush, id_flush}
    localparam logic [6:0] E_GO  = 7'b1111100;
    localparam logic [6:0] E_FRZ = 7'b0000000;
    localparam logic [6:0] E_SQ  = 7'b1111111;
    localparam logic [6:0] E_BUB = 7'b0011101;

    typedef struct {
        string    name;
        logic     ih, dh, md, mw, rd, ed;
        regbits_t ws, rs, rt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input string n, input logic ih, input logic dh,
                                input logic md, input logic mw, input logic rd,
                                input logic ed, input regbits_t ws, input regbits_t rs,
                                input regbits_t rt, input logic [6:0] e);
        vec_t v;
        v.name = n; v.ih = ih; v.dh = dh; v.md = md; v.mw = mw; v.rd = rd;
        v.ed = ed; v.ws = ws; v.rs = rs; v.rt = rt; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic chk_ctrl(input string nm, input logic [6:0] want);
        chk(nm, {25'd0, pc_wen, if_w, id_w, ex_w, mem_w, if_flush, id_flush}, {25'd0, want});
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
        ex_redirect = 1'b0; ex_dren = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle();
        nRST = 1'b0;
        #2 nRST = 1'b1;
    endtask

    initial begin
        int exp_cnt;
        idle();

        // Reset: async clear, outputs follow RUN decoding during reset
        nRST = 1'b0;
        ihit = 1'b0;
        #3;
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_cnt", {16'd0, stall_cnt}, 0);
        chk_ctrl("rst_ctrl_ihit0", E_BUB);
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        #1 chk_ctrl("post_rst_go", E_GO);

        // Table of RUN-state vectors
        vecs[0]  = mk("v_plain",       1,0,0,0,0,0, 5'd0, 5'd0, 5'd0, E_GO);
        vecs[1]  = mk("v_imiss",       0,0,0,0,0,0, 5'd0, 5'd0, 5'd0, E_BUB);
        vecs[2]  = mk("v_redir_imiss", 0,0,0,0,1,0, 5'd0, 5'd0, 5'd0, E_SQ);
        vecs[3]  = mk("v_redir",       1,0,0,0,1,0, 5'd0, 5'd0, 5'd0, E_SQ);
        vecs[4]  = mk("v_lu_rt",       1,0,0,0,0,1, 5'd5, 5'd1, 5'd5, E_BUB);
        vecs[5]  = mk("v_lu_rs",       1,0,0,0,0,1, 5'd7, 5'd7, 5'd3, E_BUB);
        vecs[6]  = mk("v_lu_r0",       1,0,0,0,0,1, 5'd0, 5'd0, 5'd0, E_GO);
        vecs[7]  = mk("v_lu_nomatch",  1,0,0,0,0,1, 5'd5, 5'd4, 5'd6, E_GO);
        vecs[8]  = mk("v_noload",      1,0,0,0,0,0, 5'd5, 5'd5, 5'd5, E_GO);
        vecs[9]  = mk("v_redir_lu",    1,0,0,0,1,1, 5'd9, 5'd9, 5'd0, E_SQ);
        vecs[10] = mk("v_lu_imiss",    0,0,0,0,0,1, 5'd3, 5'd0, 5'd3, E_BUB);
        vecs[11] = mk("v_ld_hit",      1,1,1,0,0,0, 5'd0, 5'd0, 5'd0, E_GO);
        vecs[12] = mk("v_st_hit_imiss",0,1,0,1,0,0, 5'd0, 5'd0, 5'd0, E_BUB);

        exp_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            ihit = vecs[i].ih; dhit = vecs[i].dh; mem_dren = vecs[i].md;
            mem_dwen = vecs[i].mw; ex_redirect = vecs[i].rd; ex_dren = vecs[i].ed;
            ex_wsel = vecs[i].ws; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            #1 chk_ctrl(vecs[i].name, vecs[i].exp);
            if (!vecs[i].exp[6]) exp_cnt++;
        end
        @(negedge CLK);
        idle();
        chk("table_cnt", {16'd0, stall_cnt}, exp_cnt);

        // Data miss: three frozen cycles, then release
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            mem_dren = 1'b1; dhit = 1'b0;
            #1 chk_ctrl($sformatf("dmiss_frz%0d", k), E_FRZ);
        end
        @(negedge CLK);
        dhit = 1'b1;
        #1 chk_ctrl("dmiss_release", E_GO);
        @(negedge CLK);
        idle();
        #1 chk_ctrl("dmiss_after", E_GO);
        chk("dmiss_cnt", {16'd0, stall_cnt}, 3);

        // DWAIT+dhit wins over redirect: flushes stay low
        do_reset();
        @(negedge CLK);
        mem_dren = 1'b1;
        @(negedge CLK);
        dhit = 1'b1; ex_redirect = 1'b1;
        #1 chk_ctrl("dwait_hit_redir", E_GO);

        // Reset mid-DWAIT returns to RUN (redirect then flushes)
        do_reset();
        @(negedge CLK);
        mem_dren = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        #1 chk("dwait_rst_cnt", {16'd0, stall_cnt}, 0);
        nRST = 1'b1;
        dhit = 1'b1; ex_redirect = 1'b1;
        #1 chk_ctrl("dwait_rst_run", E_SQ);

        // Load-use bubble for one cycle, then $0 destination gives no stall
        do_reset();
        @(negedge CLK);
        ex_dren = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5;
        #1 chk_ctrl("lu_bubble", E_BUB);
        @(negedge CLK);
        ex_dren = 1'b0;
        #1 chk_ctrl("lu_done", E_GO);
        @(negedge CLK);
        ex_dren = 1'b1; ex_wsel = 5'd0; id_rt = 5'd0;
        #1 chk_ctrl("lu_r0", E_GO);
        @(negedge CLK);
        idle();
        chk("lu_cnt", {16'd0, stall_cnt}, 1);

        // Halt beats a concurrent store miss; HALT is sticky until reset
        do_reset();
        @(negedge CLK);
        mem_halt = 1'b1; mem_dwen = 1'b1; dhit = 1'b0;
        #1 chk_ctrl("halt_frz", E_FRZ);
        chk("halt_not_yet", {31'd0, halted}, 0);
        @(negedge CLK);
        idle();
        ex_redirect = 1'b1;
        #1 chk("halted", {31'd0, halted}, 1);
        chk_ctrl("halt_ctrl", E_FRZ);
        repeat (3) @(negedge CLK);
        chk("halt_cnt", {16'd0, stall_cnt}, 1);
        chk_ctrl("halt_hold", E_FRZ);
        nRST = 1'b0;
        #1 chk("halt_rst", {31'd0, halted}, 0);
        nRST = 1'b1;
        ex_redirect = 1'b0;
        #1 chk_ctrl("halt_rst_run", E_GO);

        // Saturation
        do_reset();
        @(negedge CLK);
        ihit = 1'b0;
        repeat (65534) @(posedge CLK);
        @(negedge CLK);
        chk("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
        repeat (70000 - 65534) @(posedge CLK);
        @(negedge CLK);
        chk("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port ihit, input, 1, instruction fetch completed this cycle.
REQ-004 SHALL have port dhit, input, 1, data access completed this cycle.
REQ-005 SHALL have ports mem_dren and mem_dwen, input, 1 each, MEM-stage load/store pending.
REQ-006 SHALL have port mem_halt, input, 1, HALT instruction in MEM stage.
REQ-007 SHALL have port ex_redirect, input, 1, branch taken or jump/JR resolved in EX.
REQ-008 SHALL have ports ex_dren, input, 1, and ex_wsel, input, 5, load in EX and its destination.
REQ-009 SHALL have ports id_rs and id_rt, input, 5 each, source registers of the instruction in ID.
REQ-010 SHALL have ports pc_wen, if_w, id_w, ex_w and mem_w, output, 1 each, PC and IF/ID, ID/EX, EX/MEM, MEM/WB write enables.
REQ-011 SHALL have ports if_flush and id_flush, output, 1 each, load a bubble into IF/ID or ID/EX on the next edge.
REQ-012 SHALL have port halted, output, 1, processor halted (registered).
REQ-013 SHALL have port stall_cnt, output, 16, saturating count of stall cycles.

Function
REQ-014 SHALL implement FSM states RUN, DWAIT and HALT.
REQ-015 SHALL compute outputs combinationally from state and inputs, with priority as ordered in REQ-016..REQ-021; the first matching case wins.
REQ-016 SHALL, in HALT, drive all enables and flushes 0, hold halted=1, and remain in HALT until reset.
REQ-017 SHALL, in RUN with mem_halt=1, drive all enables 0 and enter HALT at the next edge.
REQ-018 SHALL, when (mem_dren|mem_dwen)=1 and dhit=0, in RUN or DWAIT, drive all enables and flushes 0; the next state is DWAIT.
REQ-019 SHALL, in DWAIT with dhit=1, drive all enables 1; the next state is RUN.
REQ-020 SHALL, with ex_redirect=1 and no higher case, drive all enables 1 with if_flush=1 and id_flush=1, squashing two wrong-path instructions, even if ihit=0.
REQ-021 SHALL, on load-use (ex_dren=1, ex_wsel!=0, ex_wsel equal to id_rs or id_rt), drive pc_wen=0, if_w=0, id_w=1, id_flush=1 and ex_w=mem_w=1, inserting one bubble.
REQ-022 SHALL, on ihit=0 with no higher case, drive pc_wen=0, if_w=0 and id_flush=1; downstream enables stay 1.
REQ-023 SHALL otherwise drive all enables 1 and flushes 0.
REQ-024 SHALL never assert a flush whose register write enable is 0 in the same cycle.
REQ-025 SHALL never treat register $0 as a load-use hazard.
REQ-026 SHALL increment stall_cnt by 1 each cycle that pc_wen=0 and the state is not HALT, saturating at 16'hFFFF with no wrap.
REQ-027 SHALL, when mem access and mem_halt are asserted together, give mem_halt priority.

Reset
REQ-028 SHALL, while nRST=0, set state=RUN, halted=0 and stall_cnt=0 asynchronously.
REQ-029 SHALL, during reset, drive all combinational enables per RUN with inputs as applied.
REQ-030 SHALL, when reset occurs mid-DWAIT or in HALT, discard the pending access and restart in RUN.

Structure
REQ-031 SHALL declare enum hazard_state_t (RUN, DWAIT, HALT) in cpu_types_pkg, with 5-bit register selects using regbits_t.
REQ-032 SHALL place the 16-bit saturating counter in one sub-module, sat_counter, parameterised by width.
REQ-033 SHALL be instantiated once in datapath, replacing its inline pipeline-enable logic.

Verification
REQ-034 SHALL cover: after reset, ihit=1 and no hazards -> all enables 1, flushes 0, stall_cnt=0.
REQ-035 SHALL cover: mem_dren=1 with dhit low 3 cycles then high -> 3 cycles of all enables 0 in DWAIT, then all 1 and RUN; stall_cnt=3.
REQ-036 SHALL cover: ex_dren=1, ex_wsel=5, id_rt=5 -> pc_wen=0, id_flush=1 for one cycle; with ex_wsel=0 -> no stall.
REQ-037 SHALL cover: ex_redirect=1 together with ihit=0 -> pc_wen=1, if_flush=1, id_flush=1.
REQ-038 SHALL cover: mem_halt=1 together with mem_dwen=1 -> halted=1 next cycle and enables 0 thereafter; nRST low then high -> RUN, halted=0.
REQ-039 SHALL cover: force 70000 stall cycles -> stall_cnt holds 16'hFFFF.
